// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and helpers for the tick generator
package tick_gen_pkg;
  localparam int COUNT_1MS = 49999;
  localparam int COUNT_REFRESH = 6249;
  localparam int CNT_W_DEF = 16;
  localparam logic [2*CNT_W_DEF-1:0] DIV_RESET_DEF = {CNT_W_DEF'(COUNT_REFRESH), CNT_W_DEF'(COUNT_1MS)};
  function automatic int ch_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_generator_if.sv
// tick_generator_if: valid/ready divisor write port
interface tick_generator_if #(parameter int CH_W = 1, parameter int CNT_W = 16);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/tick_channel.sv
// tick_channel: one divider channel with glitch-free divisor reload at terminal count
module tick_channel #(
  parameter int               CNT_W    = 16,
  parameter logic [CNT_W-1:0] DIV_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_pending,
  output logic             o_tick,
  output logic             o_sq
);
  logic [CNT_W-1:0] r_cnt, r_div, r_pdiv;
  logic r_pend, r_tick, r_sq;
  logic w_term, w_apply, w_load;
  assign w_term = r_cnt >= r_div;
  assign w_apply = i_clr | (i_en & w_term);
  assign w_load = w_apply & r_pend;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt  <= '0;
      r_div  <= DIV_INIT;
      r_pdiv <= '0;
      r_pend <= 1'b0;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else begin
      if (i_clr) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_sq   <= 1'b0;
      end else if (!i_en) begin
        r_tick <= 1'b0;
      end else if (w_term) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        r_sq   <= ~r_sq;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
      if (w_load) r_div <= r_pdiv;
      // a write accepted on the apply cycle becomes the next pending value
      if (i_wr) begin
        r_pend <= 1'b1;
        r_pdiv <= i_wr_div;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  assign o_pending = r_pend;
  assign o_tick = r_tick;
  assign o_sq = r_sq;
endmodule

// File: rtl/tick_generator.sv
// tick_generator: multi-channel tick/square generator with runtime divisor writes
module tick_generator import tick_gen_pkg::*; #(
  parameter int                          NUM_CH    = 2,
  parameter int                          CNT_W     = CNT_W_DEF,
  parameter int                          CH_W      = ch_width(NUM_CH),
  parameter logic [NUM_CH*CNT_W-1:0]     DIV_RESET = DIV_RESET_DEF
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  tick_generator_if.slave   cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);
  logic [NUM_CH-1:0] w_pend, w_wr;
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg.cfg_ch == CH_W'(i)) cfg.cfg_ready = ~w_pend[i];
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg.cfg_valid & cfg.cfg_ready & (cfg.cfg_ch == CH_W'(g));
    tick_channel #(
      .CNT_W   (CNT_W),
      .DIV_INIT(DIV_RESET[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk      (clk_100mhz),
      .rst      (rst),
      .i_en     (ch_en[g]),
      .i_clr    (sync_clr),
      .i_wr     (w_wr[g]),
      .i_wr_div (cfg.cfg_div),
      .o_pending(w_pend[g]),
      .o_tick   (tick[g]),
      .o_sq     (sq[g])
    );
  end
endmodule
